// File: rtl/loader_pkg.sv
// Shared types and field widths for the program loader and its instruction encoder.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WR_HI,
    WR_LO,
    DONE
  } state_t;

  localparam logic FMT_ADDR = 1'b0;
  localparam logic FMT_REG  = 1'b1;

  localparam int OPC_W    = 6;
  localparam int REG_W    = 3;
  localparam int REGSEL_W = 2;
  localparam int INSTR_W  = 16;

endpackage

// File: rtl/instr_encoder.sv
// Combinational packing of decoded instruction fields into the 16-bit word
// that the CPU's fetch/decode path splits back apart.
module instr_encoder
  import loader_pkg::*;
(
  input  logic                fmt,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [REGSEL_W-1:0] regsel,
  input  logic [7:0]          address,
  input  logic [REG_W-1:0]    destreg,
  input  logic [REG_W-1:0]    srcreg1,
  input  logic [REG_W-1:0]    srcreg2,
  output logic [INSTR_W-1:0]  word
);

  always_comb begin
    word = {opcode, regsel, address};
    if (fmt == FMT_REG) begin
      // Register form leaves the least significant bit as a zero pad.
      word = {opcode, destreg, srcreg1, srcreg2, 1'b0};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads encoded instructions big-endian into byte memory while holding the CPU.
// Optional running byte checksum enabled by defining LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              In_Last,
  input  logic              In_Format,
  input  logic [5:0]        In_Opcode,
  input  logic [1:0]        In_RegSel,
  input  logic [7:0]        In_Address,
  input  logic [2:0]        In_DestReg,
  input  logic [2:0]        In_SrcReg1,
  input  logic [2:0]        In_SrcReg2,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [7:0]        Mem_Data,
  output logic              Mem_CS,
  output logic              Mem_WR,
  output logic              CPU_Hold,
  output logic              Done,
  output logic [CNT_W-1:0]  Count,
  output logic [7:0]        Checksum
);

  state_t               state_reg, state_next;
  logic [ADDR_W-1:0]    ptr_reg, ptr_next;
  logic [INSTR_W-1:0]   word_reg, word_next;
  logic                 last_reg, last_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [INSTR_W-1:0]   enc_word;
  logic                 wr_active;

  instr_encoder u_enc (
    .fmt     (In_Format),
    .opcode  (In_Opcode),
    .regsel  (In_RegSel),
    .address (In_Address),
    .destreg (In_DestReg),
    .srcreg1 (In_SrcReg1),
    .srcreg2 (In_SrcReg2),
    .word    (enc_word)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      word_reg  <= '0;
      last_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      word_reg  <= word_next;
      last_reg  <= last_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    word_next  = word_reg;
    last_next  = last_reg;
    count_next = count_reg;
    unique case (state_reg)
      IDLE: begin
        if (Start) begin
          ptr_next   = BaseAddr;
          count_next = '0;
          state_next = ACCEPT;
        end
      end
      ACCEPT: begin
        if (In_Valid) begin
          word_next  = enc_word;
          last_next  = In_Last;
          state_next = WR_HI;
        end
      end
      WR_HI: begin
        ptr_next   = ptr_reg + 1'b1;
        state_next = WR_LO;
      end
      WR_LO: begin
        ptr_next   = ptr_reg + 1'b1;
        count_next = count_reg + 1'b1;
        state_next = last_reg ? DONE : ACCEPT;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign wr_active   = (state_reg == WR_HI) || (state_reg == WR_LO);
  assign In_Ready    = (state_reg == ACCEPT);
  assign CPU_Hold    = (state_reg != IDLE);
  assign Done        = (state_reg == DONE);
  // Reset gates chip select directly so a reset edge can never commit a write.
  assign Mem_CS      = Reset | ~wr_active;
  assign Mem_WR      = wr_active;
  assign Mem_Address = ptr_reg;
  assign Mem_Data    = (state_reg == WR_HI) ? word_reg[15:8] :
                       (state_reg == WR_LO) ? word_reg[7:0]  : 8'h00;
  assign Count       = count_reg;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum_reg, checksum_next;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      checksum_reg <= 8'h00;
    end else begin
      checksum_reg <= checksum_next;
    end
  end

  always_comb begin
    checksum_next = checksum_reg;
    if (state_reg == IDLE && Start) begin
      checksum_next = 8'h00;
    end else if (wr_active) begin
      checksum_next = checksum_reg + Mem_Data;
    end
  end

  assign Checksum = checksum_reg;
`else
  assign Checksum = 8'h00;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a behavioural byte memory on its write port.
module tb_program_loader;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] BaseAddr;
  logic       In_Valid;
  logic       In_Ready;
  logic       In_Last;
  logic       In_Format;
  logic [5:0] In_Opcode;
  logic [1:0] In_RegSel;
  logic [7:0] In_Address;
  logic [2:0] In_DestReg;
  logic [2:0] In_SrcReg1;
  logic [2:0] In_SrcReg2;
  logic [7:0] Mem_Address;
  logic [7:0] Mem_Data;
  logic       Mem_CS;
  logic       Mem_WR;
  logic       CPU_Hold;
  logic       Done;
  logic [7:0] Count;
  logic [7:0] Checksum;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] mem [256];
  logic       mem_clear;

  always #5 Clock = ~Clock;

  program_loader #(.ADDR_W(8), .CNT_W(8)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .BaseAddr    (BaseAddr),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .In_Last     (In_Last),
    .In_Format   (In_Format),
    .In_Opcode   (In_Opcode),
    .In_RegSel   (In_RegSel),
    .In_Address  (In_Address),
    .In_DestReg  (In_DestReg),
    .In_SrcReg1  (In_SrcReg1),
    .In_SrcReg2  (In_SrcReg2),
    .Mem_Address (Mem_Address),
    .Mem_Data    (Mem_Data),
    .Mem_CS      (Mem_CS),
    .Mem_WR      (Mem_WR),
    .CPU_Hold    (CPU_Hold),
    .Done        (Done),
    .Count       (Count),
    .Checksum    (Checksum)
  );

  always @(posedge Clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
    end else if (!Mem_CS && Mem_WR) begin
      mem[Mem_Address] <= Mem_Data;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_addr(input logic [5:0] opc, input logic [1:0] rs,
                          input logic [7:0] a, input logic last);
    In_Format  = 1'b0;
    In_Opcode  = opc;
    In_RegSel  = rs;
    In_Address = a;
    In_DestReg = 3'd0;
    In_SrcReg1 = 3'd0;
    In_SrcReg2 = 3'd0;
    In_Last    = last;
  endtask

  task automatic set_reg(input logic [5:0] opc, input logic [2:0] d,
                         input logic [2:0] s1, input logic [2:0] s2, input logic last);
    In_Format  = 1'b1;
    In_Opcode  = opc;
    In_RegSel  = 2'd0;
    In_Address = 8'h00;
    In_DestReg = d;
    In_SrcReg1 = s1;
    In_SrcReg2 = s2;
    In_Last    = last;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; BaseAddr = 8'h00; In_Valid = 1'b0;
    mem_clear = 1'b1;
    set_addr(6'h00, 2'd0, 8'h00, 1'b0);
    tick();
    mem_clear = 1'b0;
    Reset = 1'b0;

    // Reset state
    check("rst_cs", {15'd0, Mem_CS}, 16'd1);
    check("rst_wr", {15'd0, Mem_WR}, 16'd0);
    check("rst_ready", {15'd0, In_Ready}, 16'd0);
    check("rst_hold", {15'd0, CPU_Hold}, 16'd0);
    check("rst_done", {15'd0, Done}, 16'd0);
    check("rst_count", {8'd0, Count}, 16'd0);
    check("rst_addr", {8'd0, Mem_Address}, 16'd0);
    check("rst_data", {8'd0, Mem_Data}, 16'd0);
    $display("txn reset: cs=%0d ready=%0d hold=%0d count=%0d", Mem_CS, In_Ready, CPU_Hold, Count);

    // Address form 0x6401 at base 0x56
    Start = 1'b1; BaseAddr = 8'h56;
    tick();
    Start = 1'b0;
    check("t1_ready", {15'd0, In_Ready}, 16'd1);
    check("t1_hold", {15'd0, CPU_Hold}, 16'd1);
    In_Valid = 1'b1;
    set_addr(6'h19, 2'd0, 8'h01, 1'b1);
    tick();
    In_Valid = 1'b0;
    check("t1_hi_cs", {15'd0, Mem_CS}, 16'd0);
    check("t1_hi_wr", {15'd0, Mem_WR}, 16'd1);
    check("t1_hi_addr", {8'd0, Mem_Address}, 16'h56);
    check("t1_hi_data", {8'd0, Mem_Data}, 16'h64);
    check("t1_hi_ready", {15'd0, In_Ready}, 16'd0);
    tick();
    check("t1_lo_addr", {8'd0, Mem_Address}, 16'h57);
    check("t1_lo_data", {8'd0, Mem_Data}, 16'h01);
    tick();
    check("t1_done", {15'd0, Done}, 16'd1);
    check("t1_done_hold", {15'd0, CPU_Hold}, 16'd1);
    check("t1_count", {8'd0, Count}, 16'd1);
    check("t1_done_cs", {15'd0, Mem_CS}, 16'd1);
    tick();
    check("t1_idle_done", {15'd0, Done}, 16'd0);
    check("t1_idle_hold", {15'd0, CPU_Hold}, 16'd0);
    check("t1_mem56", {8'd0, mem[8'h56]}, 16'h64);
    check("t1_mem57", {8'd0, mem[8'h57]}, 16'h01);
`ifdef LOADER_CHECKSUM_EN
    check("t1_checksum", {8'd0, Checksum}, 16'h65);
`else
    check("t1_checksum", {8'd0, Checksum}, 16'h00);
`endif
    $display("txn addr-form base=56: mem[56]=%02h mem[57]=%02h count=%0d sum=%02h",
             mem[8'h56], mem[8'h57], Count, Checksum);

    // Register form 0x2AC0 at base 0x10; Start during the write must be ignored
    Start = 1'b1; BaseAddr = 8'h10;
    tick();
    Start = 1'b0;
    check("t2_count_clr", {8'd0, Count}, 16'd0);
    In_Valid = 1'b1;
    set_reg(6'h0A, 3'd5, 3'd4, 3'd0, 1'b1);
    tick();
    In_Valid = 1'b0;
    Start = 1'b1; BaseAddr = 8'h80;
    check("t2_hi_data", {8'd0, Mem_Data}, 16'h2A);
    tick();
    check("t2_lo_addr", {8'd0, Mem_Address}, 16'h11);
    check("t2_lo_data", {8'd0, Mem_Data}, 16'hC0);
    Start = 1'b0;
    tick();
    tick();
    check("t2_mem10", {8'd0, mem[8'h10]}, 16'h2A);
    check("t2_mem11", {8'd0, mem[8'h11]}, 16'hC0);
    check("t2_mem80", {8'd0, mem[8'h80]}, 16'hEE);
`ifdef LOADER_CHECKSUM_EN
    check("t2_checksum", {8'd0, Checksum}, 16'hEA);
`else
    check("t2_checksum", {8'd0, Checksum}, 16'h00);
`endif
    $display("txn reg-form base=10: mem[10]=%02h mem[11]=%02h sum=%02h",
             mem[8'h10], mem[8'h11], Checksum);

    // Two back-to-back instructions across the FF->00 wrap
    Start = 1'b1; BaseAddr = 8'hFE;
    tick();
    Start = 1'b0;
    In_Valid = 1'b1;
    set_reg(6'h12, 3'd4, 3'd4, 3'd3, 1'b0);
    tick();
    set_addr(6'h07, 2'd0, 8'h32, 1'b1);
    check("t3_gap1_ready", {15'd0, In_Ready}, 16'd0);
    check("t3_hi1_addr", {8'd0, Mem_Address}, 16'hFE);
    tick();
    check("t3_gap2_ready", {15'd0, In_Ready}, 16'd0);
    check("t3_lo1_addr", {8'd0, Mem_Address}, 16'hFF);
    tick();
    check("t3_acc2_ready", {15'd0, In_Ready}, 16'd1);
    check("t3_count_mid", {8'd0, Count}, 16'd1);
    tick();
    In_Valid = 1'b0;
    check("t3_hi2_addr", {8'd0, Mem_Address}, 16'h00);
    check("t3_hi2_data", {8'd0, Mem_Data}, 16'h1C);
    tick();
    check("t3_lo2_addr", {8'd0, Mem_Address}, 16'h01);
    tick();
    check("t3_done", {15'd0, Done}, 16'd1);
    check("t3_count", {8'd0, Count}, 16'd2);
    tick();
    check("t3_memFE", {8'd0, mem[8'hFE]}, 16'h4A);
    check("t3_memFF", {8'd0, mem[8'hFF]}, 16'h46);
    check("t3_mem00", {8'd0, mem[8'h00]}, 16'h1C);
    check("t3_mem01", {8'd0, mem[8'h01]}, 16'h32);
`ifdef LOADER_CHECKSUM_EN
    check("t3_checksum", {8'd0, Checksum}, 16'hDE);
`else
    check("t3_checksum", {8'd0, Checksum}, 16'h00);
`endif
    $display("txn wrap base=FE: mem[FE..01]=%02h %02h %02h %02h count=%0d",
             mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01], Count);

    // Reset during WR_LO leaves the instruction half-written
    Start = 1'b1; BaseAddr = 8'h20;
    tick();
    Start = 1'b0;
    In_Valid = 1'b1;
    set_addr(6'h19, 2'd0, 8'h01, 1'b1);
    tick();
    In_Valid = 1'b0;
    tick();
    check("t4_lo_cs", {15'd0, Mem_CS}, 16'd0);
    Reset = 1'b1;
    #1;
    check("t4_rst_cs_gate", {15'd0, Mem_CS}, 16'd1);
    tick();
    Reset = 1'b0;
    #1;
    check("t4_mem20", {8'd0, mem[8'h20]}, 16'h64);
    check("t4_mem21", {8'd0, mem[8'h21]}, 16'hEE);
    check("t4_ready", {15'd0, In_Ready}, 16'd0);
    check("t4_hold", {15'd0, CPU_Hold}, 16'd0);
    check("t4_count", {8'd0, Count}, 16'd0);
    check("t4_addr", {8'd0, Mem_Address}, 16'd0);
    tick();
    check("t4_idle_stays", {15'd0, CPU_Hold}, 16'd0);
    $display("txn reset-mid-write base=20: mem[20]=%02h mem[21]=%02h hold=%0d",
             mem[8'h20], mem[8'h21], CPU_Hold);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
